// File: rtl/div_sched_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the divider scheduler (div_sched) and its
//   round-robin picker (rr_arb).
//   - state_e     : scheduler FSM states.
//   - DZ_QUOTIENT : quotient returned on divide-by-zero (all-ones, sliced to
//                   the operand width by the user; operand width must be <= 64).
//   - id_width()  : width of a requester index ($clog2 with a minimum of 1).
// -----------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [63:0] DZ_QUOTIENT = '1;

  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage : div_pkg

// File: rtl/div_sched_rr_arb.sv
// -----------------------------------------------------------------------------
// rr_arb
//   Combinational round-robin picker. Searches req_i starting at ptr_i and
//   wrapping, and returns the first requester found.
//   Parameters : N  - number of requesters
//                IW - index width (>= clog2(N), at least 1)
//   Ports      : req_i [N]  request vector
//                ptr_i [IW] highest-priority index (must be < N)
//                gnt_o [N]  one-hot grant (all zero when nothing requests)
//                idx_o [IW] encoded grant index
//                any_o      at least one request present
// -----------------------------------------------------------------------------
module rr_arb #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int          pos;
  logic [IW-1:0] cand;

  // NOTE: every signal written in a combinational block gets a default at the
  // top so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    pos   = 0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      pos = int'(ptr_i) + i;
      if (pos >= N) pos = pos - N;
      cand = IW'(pos);
      // First hit wins; later candidates are masked by any_o.
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule : rr_arb

// File: rtl/div_sched.sv
// -----------------------------------------------------------------------------
// div_sched
//   Shares one multi-cycle divider among NREQ requesters. A round-robin
//   picker chooses a requester in IDLE, the operands are latched, the divider
//   is started with a one-cycle pulse, and the result is returned on a single
//   response channel tagged with the requester id. Divide-by-zero is answered
//   directly without starting the divider; a divider that never signals rdy
//   is abandoned after TIMEOUT busy cycles with resp_err set.
//
//   Parameters : BITS (operand width), NREQ (2..8), TIMEOUT (busy cycle limit)
//   Ports      : clk, rst_n (async, active-low)
//                req_valid/req_ready [NREQ], req_n/req_d [NREQ*BITS] (slice k)
//                resp_valid/resp_ready, resp_id, resp_q, resp_r, resp_dz,
//                resp_err
//                div_start, div_n, div_d (to divider)
//                div_q, div_r, div_rdy (from divider)
//
//   Build option: define SIGNED_DIV_EN for two's-complement operands
//   (truncating division, divider sees magnitudes). Unsigned when undefined.
// -----------------------------------------------------------------------------
module div_sched
  import div_pkg::*;
#(
  parameter  int BITS    = 32,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 2*BITS+4,
  localparam int IW      = id_width(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BITS-1:0] req_n,
  input  logic [NREQ*BITS-1:0] req_d,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IW-1:0]        resp_id,
  output logic [BITS-1:0]      resp_q,
  output logic [BITS-1:0]      resp_r,
  output logic                 resp_dz,
  output logic                 resp_err,
  output logic                 div_start,
  output logic [BITS-1:0]      div_n,
  output logic [BITS-1:0]      div_d,
  input  logic [BITS-1:0]      div_q,
  input  logic [BITS-1:0]      div_r,
  input  logic                 div_rdy
);

  localparam int            CW       = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);
  localparam logic [IW-1:0] ID_LAST  = IW'(NREQ-1);

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   id_q;
  logic [CW-1:0]   cnt_q;
  logic [BITS-1:0] n_q, d_q;
  logic [BITS-1:0] q_res_q, r_res_q;
  logic            valid_q, dz_q, err_q, start_q;

  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [BITS-1:0] sel_n, sel_d;
  logic [BITS-1:0] mag_n, mag_d;
  logic [BITS-1:0] fix_q, fix_r;

  rr_arb #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Accept is combinational; rst_n gates it so req_ready reads zero while the
  // block is held in reset even if requesters keep req_valid high.
  assign req_ready = (rst_n && state_q == IDLE) ? gnt : '0;

  // Operand mux for the granted requester.
  always_comb begin
    sel_n = '0;
    sel_d = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IW'(k)) begin
        sel_n = req_n[k*BITS +: BITS];
        sel_d = req_d[k*BITS +: BITS];
      end
    end
  end

`ifdef SIGNED_DIV_EN
  logic neg_q_q, neg_r_q;

  // The divider is unsigned: feed it magnitudes and restore signs afterwards.
  // The magnitude of MIN is MIN itself read as unsigned, which is exact.
  always_comb begin
    mag_n = sel_n[BITS-1] ? -sel_n : sel_n;
    mag_d = sel_d[BITS-1] ? -sel_d : sel_d;
    fix_q = neg_q_q ? -div_q : div_q;
    fix_r = neg_r_q ? -div_r : div_r;
  end
`else
  assign mag_n = sel_n;
  assign mag_d = sel_d;
  assign fix_q = div_q;
  assign fix_r = div_r;
`endif

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
`ifdef SIGNED_DIV_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            id_q <= gnt_idx;
            if (sel_d == '0) begin
              // Answered locally; the raw dividend is returned as remainder.
              q_res_q <= DZ_QUOTIENT[BITS-1:0];
              r_res_q <= sel_n;
              dz_q    <= 1'b1;
              valid_q <= 1'b1;
              state_q <= RESP;
            end else begin
              n_q     <= mag_n;
              d_q     <= mag_d;
              start_q <= 1'b1;
              state_q <= START;
`ifdef SIGNED_DIV_EN
              neg_q_q <= sel_n[BITS-1] ^ sel_d[BITS-1];
              neg_r_q <= sel_n[BITS-1];
`endif
            end
          end
        end

        START: begin
          start_q <= 1'b0;
          cnt_q   <= '0;
          state_q <= BUSY;
        end

        BUSY: begin
          // In the first busy cycle (cnt_q == 0) div_rdy still reflects the
          // previous operation and must not be trusted.
          if (cnt_q != '0 && div_rdy) begin
            q_res_q <= fix_q;
            r_res_q <= fix_r;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else if (cnt_q == CNT_LAST) begin
            q_res_q <= '0;
            r_res_q <= '0;
            err_q   <= 1'b1;
            valid_q <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        RESP: begin
          if (resp_ready) begin
            valid_q <= 1'b0;
            dz_q    <= 1'b0;
            err_q   <= 1'b0;
            ptr_q   <= (id_q == ID_LAST) ? '0 : id_q + IW'(1);
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = valid_q;
  assign resp_id    = id_q;
  assign resp_q     = q_res_q;
  assign resp_r     = r_res_q;
  assign resp_dz    = dz_q;
  assign resp_err   = err_q;
  assign div_start  = start_q;
  assign div_n      = n_q;
  assign div_d      = d_q;

endmodule : div_sched

// File: doc/div_sched.md
Name: div_sched

Overview:
- Shares one multi-cycle restoring divider among NREQ independent requesters.
- Picks a requester round-robin and sequences the divider's start/rdy handshake.
- Returns quotient/remainder on one shared response channel tagged with the requester ID.
- Sits between calculator front-end units (parser, display formatter, ALU) and the single divider instance at top level.

Parameters:
- BITS, 32, operand/result width; must match the divider.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 2*BITS+4, max cycles in BUSY before the request is aborted with an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  NREQ  per-requester request strobe.
- req_ready  out  NREQ  one-hot accept; at most one bit high.
- req_n  in  NREQ*BITS  packed dividends; requester k uses slice k.
- req_d  in  NREQ*BITS  packed divisors.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  $clog2(NREQ)  originating requester.
- resp_q  out  BITS  quotient.
- resp_r  out  BITS  remainder.
- resp_dz  out  1  divide-by-zero flag.
- resp_err  out  1  timeout flag.
- div_start  out  1  one-cycle start pulse to the divider.
- div_n  out  BITS  dividend to the divider.
- div_d  out  BITS  divisor to the divider.
- div_q  in  BITS  divider quotient.
- div_r  in  BITS  divider remainder.
- div_rdy  in  1  divider done.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr pointer=0, timeout counter=0.
  - All outputs 0, including div_start, req_ready, resp_valid and the resp_* buses.
- IDLE:
  - Grant g = first k with req_valid[k], searching from the pointer upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; the request is accepted that cycle.
  - Latch n, d and id=g.
  - If d==0, go to RESP with resp_q=all-ones, resp_r=n, resp_dz=1; the divider is not started.
  - Otherwise go to START.
  - No req_valid: stay in IDLE.
- START:
  - div_start=1 for exactly one cycle.
  - div_n/div_d are driven from the latched registers and held stable until leaving BUSY.
  - Next state: BUSY; counter cleared.
- BUSY:
  - div_rdy is ignored in the first BUSY cycle, because the divider's rdy is stale there.
  - When div_rdy=1, capture div_q/div_r into resp_q/resp_r and go to RESP.
  - If the counter reaches TIMEOUT first: resp_err=1, resp_q=0, resp_r=0, go to RESP.
- RESP:
  - resp_valid=1; all resp_* fields held stable until resp_ready=1.
  - On the handshake: pointer=id+1 mod NREQ, flags cleared, go to IDLE.
  - req_ready stays 0 in RESP.
- Latency, accept to resp_valid: BITS+3 cycles for a divider that finishes in BITS cycles after start; 1 cycle for divide-by-zero.
- Only one request is in flight at a time; no queueing.
- Fairness: a continuously-valid requester waits at most NREQ-1 grants.
- Simultaneous events:
  - resp_ready and a new req_valid in the same cycle: the response completes; the new request is granted next cycle from IDLE.
  - req_valid dropped before a grant: no effect.
- Reset mid-operation: return to IDLE immediately and drop any in-flight result. The next START pulse reinitialises the divider.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement; the divider receives magnitudes.
  - q is negated when the operand signs differ.
  - r takes the sign of n (truncating division).
  - MIN/-1 yields q=MIN (wraps), r=0.
  - Divide-by-zero gives q=all-ones, r=n, unchanged from the unsigned case.
- Undefined: all operands and results are unsigned; no sign logic is synthesised.

Decomposition:
- Shared package div_pkg:
  - State enum (IDLE, START, BUSY, RESP).
  - DZ_QUOTIENT constant (all-ones).
  - Function for the id width ($clog2 wrapper, min 1).
- Sub-module rr_arb:
  - Combinational round-robin picker.
  - Inputs: request vector, pointer. Outputs: one-hot grant, encoded index, any.
  - Reusable by other shared calculator resources.

Test Plan:
- Single request, id 2, n=100, d=7: resp_q=14, resp_r=2, resp_id=2, dz=0, err=0; exactly one div_start pulse.
- Divide by zero, id 0, n=5, d=0: resp_valid on the next cycle with q=FFFFFFFF, r=5, dz=1; div_start never asserted.
- All four req_valid held high, 8 transactions: grant order 0,1,2,3,0,1,2,3; resp_id matches each grant.
- resp_ready held low 10 cycles in RESP: resp_* stable; req_ready stays 0 although req_valid=1; accept happens on release.
- rst_n pulsed low mid-BUSY, then request 9/4: outputs zero during reset; the new result is q=2, r=1. Separately, div_rdy tied low gives resp_err=1 after TIMEOUT cycles.
- SIGNED_DIV_EN defined: -7/2 gives q=-3, r=-1; 7/-2 gives q=-3, r=1; 0x80000000/-1 gives q=0x80000000, r=0.
